// File: rtl/result_pkg.sv
// Shared constants and types for the result collection / drain slice.
// Sizes here set the lane count, per-lane depth and word width.
package result_pkg;

  localparam int DATA_W    = 32;
  localparam int NUM_LANES = 4;
  localparam int DEPTH     = 4;

  localparam int NUM_WORDS = NUM_LANES * DEPTH;
  localparam int IDX_W     = $clog2(NUM_WORDS);
  localparam int PTR_W     = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN,
    DONE
  } drain_state_t;

  typedef logic [DATA_W-1:0] result_word_t;

endpackage

// File: rtl/result_lane_writer.sv
// One result lane: fill pointer, ready generation, write strobe
// and overflow detection for a single row of the core.
import result_pkg::*;

module result_lane_writer (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             collect,
  input  logic             drain,
  input  logic             lane_valid,
  output logic             lane_ready,
  output logic             wr_en,
  output logic             last,
  output logic             ovf,
  output logic [PTR_W-1:0] ptr
);

  logic full;

  assign full       = (ptr == PTR_W'(DEPTH));
  assign lane_ready = collect & ~full;
  assign wr_en      = lane_valid & lane_ready;

  // Lane is full now or becomes full at this edge.
  assign last = full |
    (wr_en & (ptr == PTR_W'(DEPTH - 1)));

  assign ovf = lane_valid &
    ((collect & full) | drain);

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (wr_en) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/result_drain_ctrl.sv
// Collects per-lane results into a store, then streams it out.
// Define RESULT_DRAIN_TRANSPOSE_EN for column-major drain order.
import result_pkg::*;

module result_drain_ctrl (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [NUM_LANES-1:0]               lane_valid,
  input  logic [NUM_LANES-1:0][DATA_W-1:0]   lane_data,
  output logic [NUM_LANES-1:0]               lane_ready,
  output logic                               out_valid,
  output logic [DATA_W-1:0]                  out_data,
  output logic [IDX_W-1:0]                   out_index,
  input  logic                               out_ready,
  output logic                               busy,
  output logic                               done,
  output logic                               overflow_err
);

  drain_state_t state, state_nxt;

  result_word_t store [NUM_WORDS];

  logic [IDX_W-1:0] k;
  logic [IDX_W-1:0] addr;

  logic [NUM_LANES-1:0]            wr_en;
  logic [NUM_LANES-1:0]            last;
  logic [NUM_LANES-1:0]            ovf;
  logic [NUM_LANES-1:0][PTR_W-1:0] ptr;

  logic arm;
  logic collect_st;
  logic drain_st;
  logic xfer;
  logic last_xfer;

  assign arm        = (state == IDLE) & start;
  assign collect_st = (state == COLLECT);
  assign drain_st   = (state == DRAIN);
  assign xfer       = drain_st & out_ready;
  assign last_xfer  = xfer &
    (k == IDX_W'(NUM_WORDS - 1));

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    result_lane_writer u_lane (
      .clk        (clk),
      .reset      (reset),
      .clear      (arm),
      .collect    (collect_st),
      .drain      (drain_st),
      .lane_valid (lane_valid[g]),
      .lane_ready (lane_ready[g]),
      .wr_en      (wr_en[g]),
      .last       (last[g]),
      .ovf        (ovf[g]),
      .ptr        (ptr[g])
    );
  end

`ifdef RESULT_DRAIN_TRANSPOSE_EN
  // Column-major: walk one entry from every lane before advancing.
  assign addr = IDX_W'(
    (int'(k) % NUM_LANES) * DEPTH +
    (int'(k) / NUM_LANES));
`else
  assign addr = k;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = COLLECT;
      COLLECT: if (&last) state_nxt = DRAIN;
      DRAIN:   if (last_xfer) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = drain_st;
    busy      = collect_st | drain_st;
    done      = (state == DONE);
    out_index = addr;
    out_data  = '0;
    if (drain_st) out_data = store[addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k <= '0;
    end else if (arm || last_xfer) begin
      k <= '0;
    end else if (xfer) begin
      k <= k + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_err <= 1'b0;
    end else if (arm) begin
      overflow_err <= 1'b0;
    end else if (|ovf) begin
      overflow_err <= 1'b1;
    end
  end

  // Store is data-only; contents are never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (wr_en[i]) begin
        store[IDX_W'(i * DEPTH) + IDX_W'(ptr[i])]
          <= lane_data[i];
      end
    end
  end

endmodule
